// File: rtl/topk_block_select.sv
// Streaming top-K selector: keeps the K best (score, block index) pairs, then writes their indices by rank.
// Latency: start at edge 0 with continuous valid -> done in cycle N + k_eff + 1 (cycle 1 when N == 0).
// Backpressure: score_ready is high for every COLLECT cycle, one beat per cycle; no beat is taken in any other state.
// Ports: clk/rst (async active-high); start, num_blocks, k_sel launch a run; score_valid/score_ready/score_data
// carry one score per block; idx_wen/idx_waddr/idx_wdata write the index RAM; sel_count, busy, done report status.
module topk_block_select #(
    parameter int K       = 4,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        num_blocks,
    input  logic [3:0]         k_sel,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_data,
    output logic               idx_wen,
    output logic [15:0]        idx_waddr,
    output logic [15:0]        idx_wdata,
    output logic [3:0]         sel_count,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        n_q, n_d;
    logic [15:0]        blk_cnt_q, blk_cnt_d;
    logic [3:0]         k_eff_q, k_eff_d;
    logic [3:0]         rank_q, rank_d;
    logic [3:0]         sel_count_q, sel_count_d;
    logic [SCORE_W-1:0] score_q [K];
    logic [SCORE_W-1:0] score_d [K];
    logic [15:0]        idx_q   [K];
    logic [15:0]        idx_d   [K];
    logic [K-1:0]       vld_q, vld_d;

    // Insertion helpers: ge[i] means slot i outranks the incoming beat (ties keep the older entry on top).
    logic [K-1:0]       ge;
    logic [K:0]         ge_ext;
    logic [SCORE_W-1:0] sh_score [K];
    logic [15:0]        sh_idx   [K];
    logic [K-1:0]       sh_vld;
    logic [3:0]         k_clamp;
    logic [3:0]         k_eff_new;

    always_comb begin
        k_clamp   = (k_sel == 4'd0 || k_sel > 4'(K)) ? 4'(K) : k_sel;
        k_eff_new = ({12'd0, k_clamp} > num_blocks) ? num_blocks[3:0] : k_clamp;
    end

    // The list stays sorted with valid entries packed at the front, so ge is a run of ones
    // and the new beat lands at the first slot that does not outrank it.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            ge[i] = vld_q[i] && (score_q[i] >= score_data);
        end
        ge_ext      = {ge, 1'b1};
        sh_score[0] = score_data;
        sh_idx[0]   = blk_cnt_q;
        sh_vld[0]   = 1'b1;
        for (int i = 1; i < K; i++) begin
            sh_score[i] = score_q[i-1];
            sh_idx[i]   = idx_q[i-1];
            sh_vld[i]   = vld_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        blk_cnt_d   = blk_cnt_q;
        k_eff_d     = k_eff_q;
        rank_d      = rank_q;
        sel_count_d = sel_count_q;
        score_d     = score_q;
        idx_d       = idx_q;
        vld_d       = vld_q;
        score_ready = 1'b0;
        idx_wen     = 1'b0;
        idx_waddr   = 16'd0;
        idx_wdata   = 16'd0;
        done        = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d         = num_blocks;
                    k_eff_d     = k_eff_new;
                    blk_cnt_d   = 16'd0;
                    rank_d      = 4'd0;
                    vld_d       = '0;
                    sel_count_d = 4'd0;
                    state_d     = (num_blocks == 16'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                busy        = 1'b1;
                score_ready = 1'b1;
                if (score_valid) begin
                    // Slots at or beyond k_eff are never filled, so the entry shifted out of
                    // slot k_eff-1 (or a beat below every kept entry) simply disappears.
                    for (int i = 0; i < K; i++) begin
                        if (4'(i) < k_eff_q && !ge[i]) begin
                            if (ge_ext[i]) begin
                                score_d[i] = score_data;
                                idx_d[i]   = blk_cnt_q;
                                vld_d[i]   = 1'b1;
                            end else begin
                                score_d[i] = sh_score[i];
                                idx_d[i]   = sh_idx[i];
                                vld_d[i]   = sh_vld[i];
                            end
                        end
                    end
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    if (blk_cnt_q == n_q - 16'd1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                busy      = 1'b1;
                idx_wen   = 1'b1;
                idx_waddr = {12'd0, rank_q};
                for (int i = 0; i < K; i++) begin
                    if (rank_q == 4'(i)) begin
                        idx_wdata = idx_q[i];
                    end
                end
                rank_d = rank_q + 4'd1;
                if (rank_q == k_eff_q - 4'd1) begin
                    sel_count_d = k_eff_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_count = sel_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= 16'd0;
            blk_cnt_q   <= 16'd0;
            k_eff_q     <= 4'd0;
            rank_q      <= 4'd0;
            sel_count_q <= 4'd0;
            vld_q       <= '0;
            for (int i = 0; i < K; i++) begin
                score_q[i] <= '0;
                idx_q[i]   <= 16'd0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            blk_cnt_q   <= blk_cnt_d;
            k_eff_q     <= k_eff_d;
            rank_q      <= rank_d;
            sel_count_q <= sel_count_d;
            vld_q       <= vld_d;
            score_q     <= score_d;
            idx_q       <= idx_d;
        end
    end
endmodule

// File: tb/tb_topk_block_select.sv
module tb_topk_block_select;
    localparam int K  = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   num_blocks = 16'd0;
    logic [3:0]    k_sel = 4'd0;
    logic          score_valid = 1'b0;
    logic          score_ready;
    logic [SW-1:0] score_data = '0;
    logic          idx_wen;
    logic [15:0]   idx_waddr;
    logic [15:0]   idx_wdata;
    logic [3:0]    sel_count;
    logic          busy;
    logic          done;
    logic [39:0]   outs;

    topk_block_select #(.K(K), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks), .k_sel(k_sel),
        .score_valid(score_valid), .score_ready(score_ready), .score_data(score_data),
        .idx_wen(idx_wen), .idx_waddr(idx_waddr), .idx_wdata(idx_wdata),
        .sel_count(sel_count), .busy(busy), .done(done)
    );

    assign outs = {score_ready, idx_wen, idx_waddr, idx_wdata, sel_count, busy, done};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int sc[$];
    bit vpat[0:400];
    int w_cyc[$];
    int w_addr[$];
    int w_data[$];
    int done_cyc, done_cnt, done_sel, ready_bad, busy_seen, off_nz;
    bit timeout;
    logic [39:0] rst_vec, rst_vec2;

    // Starts a run (start sampled at edge 0), then samples outputs #1 after each edge;
    // the sample after edge c-1 is cycle c. Inputs for cycle c are driven right after sampling.
    task automatic run(input int n, input int ks, input int restart_cyc, input int restart_ks, input int rst_cyc);
        int b = 0;
        w_cyc.delete(); w_addr.delete(); w_data.delete();
        done_cyc = -1; done_cnt = 0; done_sel = -1; ready_bad = 0; busy_seen = 0; off_nz = 0; timeout = 0;
        @(posedge clk); #1;
        start = 1'b1; num_blocks = 16'(n); k_sel = 4'(ks); score_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (idx_wen) begin
                w_cyc.push_back(cyc); w_addr.push_back(int'(idx_waddr)); w_data.push_back(int'(idx_wdata));
            end else if (idx_waddr != 16'd0 || idx_wdata != 16'd0) begin
                off_nz++;
            end
            if (busy) busy_seen++;
            if (score_ready != (busy && !idx_wen)) ready_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; done_sel = int'(sel_count); end
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1; #1; rst_vec = outs;
                @(posedge clk); #1; rst_vec2 = outs; rst = 1'b0;
                break;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) k_sel = 4'(restart_ks);
            score_valid = vpat[cyc];
            score_data  = (b < sc.size()) ? SW'(sc[b]) : '0;
            if (score_valid && score_ready && b < n) b++;
            @(posedge clk); #1;
        end
        start = 1'b0; score_valid = 1'b0;
        if (done_cyc < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (outs !== 40'd0) begin n_fail++; $display("FAIL reset_hold outs=%h want 0", outs); end
        @(posedge clk); #1; rst = 1'b0; score_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (outs !== 40'd0) begin n_fail++; $display("FAIL reset_release outs=%h want 0", outs); end
        score_valid = 1'b0;
    endtask

    task automatic test_basic();
        int exp_d[$] = '{1, 3, 5, 2};
        sc = '{10, 50, 30, 50, 5, 40};
        for (int i = 0; i <= 400; i++) vpat[i] = 1'b1;
        run(6, 4, -1, 0, -1);
        n_tests++;
        if (timeout || done_cyc !== 11) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 11", done_cyc); end
        n_tests++;
        if (w_cyc.size() !== 4) begin n_fail++; $display("FAIL basic_write_count got %0d want 4", w_cyc.size()); end
        for (int r = 0; r < 4 && r < w_cyc.size(); r++) begin
            n_tests++;
            if (w_addr[r] !== r || w_data[r] !== exp_d[r] || w_cyc[r] !== 7 + r) begin
                n_fail++;
                $display("FAIL basic_write%0d got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         r, w_addr[r], w_data[r], w_cyc[r], r, exp_d[r], 7 + r);
            end
        end
        n_tests++;
        if (done_sel !== 4 || done_cnt !== 1 || int'(sel_count) !== 4) begin
            n_fail++; $display("FAIL basic_status sel=%0d done_cnt=%0d hold=%0d want 4/1/4", done_sel, done_cnt, sel_count);
        end
        n_tests++;
        if (ready_bad !== 0 || off_nz !== 0) begin
            n_fail++; $display("FAIL basic_ready_idle got ready_bad=%0d off_nz=%0d want 0/0", ready_bad, off_nz);
        end
    endtask

    task automatic test_small_n();
        sc = '{7, 9};
        for (int i = 0; i <= 400; i++) vpat[i] = 1'b1;
        run(2, 4, -1, 0, -1);
        n_tests++;
        if (w_cyc.size() !== 2 || done_cyc !== 5 || done_sel !== 2) begin
            n_fail++; $display("FAIL small_status got writes=%0d done=%0d sel=%0d want 2/5/2", w_cyc.size(), done_cyc, done_sel);
        end
        n_tests++;
        if (w_cyc.size() == 2 && (w_data[0] !== 1 || w_data[1] !== 0 || w_addr[1] !== 1)) begin
            n_fail++; $display("FAIL small_writes got %0d,%0d want 1,0", w_data[0], w_data[1]);
        end
    endtask

    task automatic test_zero();
        sc.delete();
        run(0, 4, -1, 0, -1);
        n_tests++;
        if (w_cyc.size() !== 0 || done_cyc !== 1 || done_sel !== 0 || busy_seen !== 0) begin
            n_fail++; $display("FAIL zero_n got writes=%0d done=%0d sel=%0d busy=%0d want 0/1/0/0",
                               w_cyc.size(), done_cyc, done_sel, busy_seen);
        end
    endtask

    task automatic test_gaps();
        int exp_d[$] = '{1, 3, 5, 2};
        sc = '{10, 50, 30, 50, 5, 40};
        for (int i = 0; i <= 400; i++) vpat[i] = (i % 2 == 1);
        run(6, 4, -1, 0, -1);
        n_tests++;
        if (done_cyc !== 16 || ready_bad !== 0) begin
            n_fail++; $display("FAIL gaps_timing got done=%0d ready_bad=%0d want 16/0", done_cyc, ready_bad);
        end
        n_tests++;
        if (w_cyc.size() !== 4) begin n_fail++; $display("FAIL gaps_write_count got %0d want 4", w_cyc.size()); end
        for (int r = 0; r < 4 && r < w_cyc.size(); r++) begin
            n_tests++;
            if (w_addr[r] !== r || w_data[r] !== exp_d[r] || w_cyc[r] !== 12 + r) begin
                n_fail++; $display("FAIL gaps_write%0d got data=%0d cyc=%0d want data=%0d cyc=%0d",
                                   r, w_data[r], w_cyc[r], exp_d[r], 12 + r);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp_d[$] = '{1, 3, 5, 2};
        int idle_bad = 0;
        sc = '{10, 50, 30, 50, 5, 40};
        for (int i = 0; i <= 400; i++) vpat[i] = 1'b1;
        run(6, 4, -1, 0, 3);
        n_tests++;
        if (rst_vec !== 40'd0 || rst_vec2 !== 40'd0 || busy_seen !== 3) begin
            n_fail++; $display("FAIL rstmid_outputs got %h/%h busy=%0d want 0/0/3", rst_vec, rst_vec2, busy_seen);
        end
        score_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (busy || score_ready || done || idx_wen) idle_bad++;
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        n_tests++;
        if (idle_bad !== 0) begin n_fail++; $display("FAIL rstmid_idle got %0d active cycles want 0", idle_bad); end
        run(6, 4, -1, 0, -1);
        n_tests++;
        if (done_cyc !== 11 || w_cyc.size() !== 4 || done_sel !== 4) begin
            n_fail++; $display("FAIL rstmid_rerun got done=%0d writes=%0d sel=%0d want 11/4/4", done_cyc, w_cyc.size(), done_sel);
        end
        for (int r = 0; r < 4 && r < w_cyc.size(); r++) begin
            n_tests++;
            if (w_data[r] !== exp_d[r]) begin
                n_fail++; $display("FAIL rstmid_write%0d got %0d want %0d", r, w_data[r], exp_d[r]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int exp_d[$] = '{4, 3, 2, 1};
        sc = '{1, 2, 3, 4, 5};
        for (int i = 0; i <= 400; i++) vpat[i] = 1'b1;
        run(5, 0, 3, 1, -1);
        n_tests++;
        if (done_cyc !== 10 || done_sel !== 4 || w_cyc.size() !== 4) begin
            n_fail++; $display("FAIL restart_status got done=%0d sel=%0d writes=%0d want 10/4/4", done_cyc, done_sel, w_cyc.size());
        end
        for (int r = 0; r < 4 && r < w_cyc.size(); r++) begin
            n_tests++;
            if (w_data[r] !== exp_d[r]) begin
                n_fail++; $display("FAIL restart_write%0d got %0d want %0d", r, w_data[r], exp_d[r]);
            end
        end
    endtask

    // Reference: k_eff from the clamp rule, then repeatedly pick the best unused block
    // (highest score, earliest index on ties) and predict timing from the valid pattern.
    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int n  = $urandom_range(0, 20);
            int ks = $urandom_range(0, 15);
            int keff, last, seen, exp_done;
            int exp_d[$];
            bit used[64];
            sc.delete();
            for (int j = 0; j < n; j++) sc.push_back($urandom_range(0, 7));
            for (int i = 0; i <= 400; i++) vpat[i] = ($urandom_range(0, 3) != 0);
            keff = (ks == 0 || ks > K) ? K : ks;
            if (keff > n) keff = n;
            for (int j = 0; j < 64; j++) used[j] = 1'b0;
            for (int r = 0; r < keff; r++) begin
                int best = -1;
                for (int j = 0; j < n; j++)
                    if (!used[j] && (best < 0 || sc[j] > sc[best])) best = j;
                used[best] = 1'b1;
                exp_d.push_back(best);
            end
            last = 0; seen = 0;
            for (int c = 1; c <= 400 && seen < n; c++) if (vpat[c]) begin seen++; last = c; end
            exp_done = (n == 0) ? 1 : last + keff + 1;
            run(n, ks, -1, 0, -1);
            n_tests++;
            if (timeout || done_cyc !== exp_done || done_sel !== keff || done_cnt !== 1) begin
                n_fail++; $display("FAIL rand%0d_status got done=%0d sel=%0d cnt=%0d want %0d/%0d/1",
                                   it, done_cyc, done_sel, done_cnt, exp_done, keff);
            end
            n_tests++;
            if (w_cyc.size() !== keff || ready_bad !== 0 || off_nz !== 0) begin
                n_fail++; $display("FAIL rand%0d_writes got count=%0d ready_bad=%0d off_nz=%0d want %0d/0/0",
                                   it, w_cyc.size(), ready_bad, off_nz, keff);
            end
            for (int r = 0; r < keff && r < w_cyc.size(); r++) begin
                n_tests++;
                if (w_addr[r] !== r || w_data[r] !== exp_d[r] || w_cyc[r] !== last + 1 + r) begin
                    n_fail++; $display("FAIL rand%0d_write%0d got addr=%0d data=%0d cyc=%0d want %0d/%0d/%0d",
                                       it, r, w_addr[r], w_data[r], w_cyc[r], r, exp_d[r], last + 1 + r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_n();
        test_zero();
        test_gaps();
        test_reset_mid();
        test_restart_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/topk_block_select.md
Name: topk_block_select

Overview:
- Streaming top-K block selector that sits directly upstream of the block-structured gather stage.
- Consumes one relevance score per key block, keeps the K highest-scoring block indices, then writes them into the block index RAM that the gather stage reads.
- Runs once per `start`; `done` tells the sequencer that the gather can be launched.

Parameters:
- K, 4, maximum number of selected blocks (legal 1..8).
- SCORE_W, 16, unsigned score width.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch; sampled only in IDLE.
- num_blocks  in  16  number of scores to consume (N); latched on start.
- k_sel  in  4  requested selection count; 0 or >K means K; latched on start.
- score_valid  in  1  score beat valid.
- score_ready  out  1  block accepts a beat.
- score_data  in  SCORE_W  unsigned score for block index = beat ordinal.
- idx_wen  out  1  index RAM write enable.
- idx_waddr  out  16  index RAM write address (rank).
- idx_wdata  out  16  selected block index.
- sel_count  out  4  number of entries written (k_eff); valid from DONE until the next start.
- busy  out  1  high in COLLECT or FLUSH.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; list, counters and sel_count clear.
  - All outputs are 0 while rst is high and after release.
  - Reset asserted mid-operation aborts the run; partial writes are not undone.
- States: IDLE, COLLECT, FLUSH, DONE. Encoding is free.
- IDLE:
  - On start, latch N and k_eff = min(clamp(k_sel), N), where clamp maps 0 or >K to K.
  - Clear the list and the beat counter blk_cnt.
  - Next state is COLLECT, or DONE directly if N==0.
  - start in any other state is ignored.
- COLLECT:
  - score_ready=1 every cycle; score_ready=0 in all other states. Beats offered outside COLLECT are not consumed.
  - A handshake (valid & ready) assigns the beat to block index blk_cnt and increments blk_cnt.
  - Each accepted beat is inserted, in the same cycle, into a K-entry sorted register list: descending score.
  - Ties: an earlier block index ranks higher, so a new entry goes after equal scores.
  - The list holds at most k_eff entries; an entry pushed past k_eff is dropped, and a new score below all k_eff entries is discarded.
  - Full throughput: one beat per cycle, no internal stall.
  - The handshake with blk_cnt==N-1 moves the state to FLUSH.
- FLUSH:
  - One write per cycle for r = 0..k_eff-1: idx_wen=1, idx_waddr=r, idx_wdata=list[r].idx.
  - After r==k_eff-1, next state is DONE.
  - idx_wen is 0 in every other state; idx_waddr and idx_wdata are 0 when idx_wen=0.
- DONE:
  - done=1 for exactly one cycle; sel_count=k_eff.
  - Next state is IDLE.
- Latency: with start sampled at edge 0 and valid held high, done is high in cycle N+k_eff+1 (cycle 1 when N==0).
- Widths:
  - Compare scores unsigned at SCORE_W.
  - blk_cnt is 16 bit and never wraps, because N ≤ 65535.
  - Block indices are 16 bit.

Test Plan:
1. K=4, k_sel=4, N=6, scores 10,50,30,50,5,40 with continuous valid -> writes addr0..3 = 1,3,5,2; idx_wen high cycles 7..10; done at cycle 11; sel_count=4.
2. k_sel=4, N=2, scores 7,9 -> k_eff=2; writes addr0=1, addr1=0; done at cycle 5; sel_count=2; no write to addr2/3.
3. N=0, start -> no idx_wen; done at cycle 1; sel_count=0; busy never high.
4. Same stimulus as test 1, but score_valid low on alternate cycles -> identical writes; score_ready high throughout COLLECT; done delayed by the 5 idle cycles.
5. rst asserted in cycle 3 of COLLECT -> all outputs 0 in the same cycle; state IDLE; a subsequent start with test 1 stimulus gives test 1 results.
6. k_sel=0, N=5, scores 1,2,3,4,5, with start pulsed again while busy -> k_eff=K=4; writes 4,3,2,1; the second start has no effect.
